// File: rtl/clk_div_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_pkg
// Shared constants for the clock-divider bank: system clock frequency, default
// counter width, the standard half-periods used across the product (display
// multiplexing, blink rates, elevator timed states) and a helper that converts
// a toggle frequency into a half-period in system-clock cycles.
// -----------------------------------------------------------------------------
package clk_div_pkg;

    localparam int CLK_HZ    = 100_000_000;
    localparam int DEF_CNT_W = 28;

    // Half-period (clk cycles between toggles) for a square wave of 'hz'.
    function automatic logic [DEF_CNT_W-1:0] hz_to_hp(input int hz);
        return DEF_CNT_W'(CLK_HZ / (2 * hz));
    endfunction

    localparam logic [DEF_CNT_W-1:0] HP_500HZ = hz_to_hp(500);  // 100_000
    localparam logic [DEF_CNT_W-1:0] HP_1HZ   = hz_to_hp(1);    // 50_000_000
    localparam logic [DEF_CNT_W-1:0] HP_2HZ   = hz_to_hp(2);    // 25_000_000
    localparam logic [DEF_CNT_W-1:0] HP_5HZ   = hz_to_hp(5);    // 10_000_000

endpackage

// File: rtl/clk_div_ch.sv
// -----------------------------------------------------------------------------
// clk_div_ch
// One divider channel. Counts enabled cycles 0..H-1 and, at each wrap, toggles
// the square wave and raises a one-cycle tick. A reload written while running
// is parked in a shadow register and becomes active at the next wrap, so the
// half-period in progress is never cut short or stretched.
//
// Ports:
//   clk, rst_n : system clock, synchronous active-low reset
//   en         : run enable; when low, phase is frozen
//   sync       : restart phase at zero and apply any pending reload now
//   wr         : validated load addressed to this channel
//   wr_now     : load coinciding with sync; write the active half-period directly
//   val        : half-period value that goes with wr / wr_now
//   tick       : one-cycle pulse on every toggle of sq
//   sq         : square wave, period 2*H
// -----------------------------------------------------------------------------
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int               CNT_W = DEF_CNT_W,
    parameter logic [CNT_W-1:0] INIT  = CNT_W'(1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic             wr_now,
    input  logic [CNT_W-1:0] val,
    output logic             tick,
    output logic             sq
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] shadow;
    logic             pend;
    logic             wrap;

    // div >= 1 always holds, so div-1 never underflows.
    assign wrap = (cnt == div - ONE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            div    <= INIT;
            shadow <= INIT;
            pend   <= 1'b0;
            sq     <= 1'b0;
            tick   <= 1'b0;
        end else if (sync) begin
            cnt  <= '0;
            sq   <= 1'b0;
            tick <= 1'b0;
            pend <= 1'b0;
            if (wr_now) begin
                div    <= val;
                shadow <= val;
            end else if (pend) begin
                div <= shadow;
            end
        end else begin
            tick <= 1'b0;
            if (en) begin
                if (wrap) begin
                    cnt  <= '0;
                    sq   <= ~sq;
                    tick <= 1'b1;
                    if (pend) begin
                        div  <= shadow;
                        pend <= 1'b0;
                    end
                end else begin
                    cnt <= cnt + ONE;
                end
            end
            // Placed after the wrap handling: a load landing on a wrap edge
            // stays pending for the following wrap, while the wrap consumes
            // the previously shadowed value.
            if (wr) begin
                shadow <= val;
                pend   <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/clk_div_bank.sv
// -----------------------------------------------------------------------------
// clk_div_bank
// Bank of NUM_CH independent clock dividers. Decodes and validates reload
// requests, reports rejected loads, and fans sync out to every channel.
//
// Ports:
//   clk, rst_n : system clock, synchronous active-low reset
//   en         : per-channel run enable
//   sync       : one-cycle strobe, realigns all channels
//   load       : one-cycle strobe, write load_val to channel load_ch
//   load_ch    : target channel index
//   load_val   : new half-period in clk cycles (0 is rejected)
//   tick       : per-channel one-cycle pulse at each sq toggle
//   sq         : per-channel 50 % square wave
//   load_err   : one-cycle pulse when a load is rejected
// -----------------------------------------------------------------------------
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int                      NUM_CH   = 4,
    parameter int                      CNT_W    = DEF_CNT_W,
    parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT = {HP_5HZ, HP_2HZ, HP_1HZ, HP_500HZ},
    parameter int                      CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] en,
    input  logic              sync,
    input  logic              load,
    input  logic [CH_W-1:0]   load_ch,
    input  logic [CNT_W-1:0]  load_val,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] sq,
    output logic              load_err
);

    // One extra bit so the range check also works when NUM_CH is a power of two.
    localparam logic [CH_W:0] NUM_CH_C = (CH_W + 1)'(NUM_CH);

    logic              load_ok;
    logic [NUM_CH-1:0] wr_sel;

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        wr_sel  = '0;
        load_ok = load && (load_val != '0) && ({1'b0, load_ch} < NUM_CH_C);
        for (int i = 0; i < NUM_CH; i++) begin
            if (load_ok && (load_ch == CH_W'(i))) begin
                wr_sel[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            load_err <= 1'b0;
        end else begin
            load_err <= load && !load_ok;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clk_div_ch #(
            .CNT_W (CNT_W),
            .INIT  (DIV_INIT[g*CNT_W +: CNT_W])
        ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .en     (en[g]),
            .sync   (sync),
            .wr     (wr_sel[g]),
            .wr_now (wr_sel[g] & sync),
            .val    (load_val),
            .tick   (tick[g]),
            .sq     (sq[g])
        );
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// -----------------------------------------------------------------------------
// tb_clk_div_bank
// Self-checking bench for clk_div_bank with three small channels. A reference
// model tracks, per channel, the number of enabled cycles remaining until the
// next toggle, the active half-period and an optional queued reload; it is
// stepped once per clock and compared against the DUT one time unit later.
// -----------------------------------------------------------------------------
module tb_clk_div_bank;

    localparam int NCH = 3;
    localparam int CW  = 8;
    localparam int HW  = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NCH-1:0] en;
    logic           sync;
    logic           load;
    logic [HW-1:0]  load_ch;
    logic [CW-1:0]  load_val;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] sq;
    logic           load_err;

    clk_div_bank #(
        .NUM_CH   (NCH),
        .CNT_W    (CW),
        .DIV_INIT ({8'd5, 8'd3, 8'd2})
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .sync     (sync),
        .load     (load),
        .load_ch  (load_ch),
        .load_val (load_val),
        .tick     (tick),
        .sq       (sq),
        .load_err (load_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Reference model state.
    int             init_h [NCH] = '{2, 3, 5};
    int             rem    [NCH];
    int             h      [NCH];
    int             nxt    [NCH];
    bit             pnd    [NCH];
    logic [NCH-1:0] m_sq;
    logic [NCH-1:0] m_tick;
    logic           m_err;

    // Advance the model by one rising edge using the inputs sampled there.
    task automatic model_edge();
        bit valid;
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                rem[i] = init_h[i];
                h[i]   = init_h[i];
                pnd[i] = 1'b0;
            end
            m_sq   = '0;
            m_tick = '0;
            m_err  = 1'b0;
        end else begin
            valid = load && (load_val != 0) && (int'(load_ch) < NCH);
            m_err = load && !valid;
            for (int i = 0; i < NCH; i++) begin
                bit hit;
                hit = valid && (int'(load_ch) == i);
                if (sync) begin
                    if (hit)         h[i] = int'(load_val);
                    else if (pnd[i]) h[i] = nxt[i];
                    pnd[i]    = 1'b0;
                    rem[i]    = h[i];
                    m_sq[i]   = 1'b0;
                    m_tick[i] = 1'b0;
                end else begin
                    m_tick[i] = 1'b0;
                    if (en[i]) begin
                        rem[i]--;
                        if (rem[i] == 0) begin
                            m_sq[i]   = ~m_sq[i];
                            m_tick[i] = 1'b1;
                            if (pnd[i]) begin
                                h[i]   = nxt[i];
                                pnd[i] = 1'b0;
                            end
                            rem[i] = h[i];
                        end
                    end
                    if (hit) begin
                        nxt[i] = int'(load_val);
                        pnd[i] = 1'b1;
                    end
                end
            end
        end
    endtask

    // Apply one cycle of stimulus, step the model, then compare outputs.
    task automatic step(input logic r, input logic [NCH-1:0] e, input logic s,
                        input logic l, input logic [HW-1:0] c, input logic [CW-1:0] v);
        rst_n    = r;
        en       = e;
        sync     = s;
        load     = l;
        load_ch  = c;
        load_val = v;
        @(posedge clk);
        model_edge();
        #1;
        check("tick", 32'(tick), 32'(m_tick));
        check("sq", 32'(sq), 32'(m_sq));
        check("load_err", 32'(load_err), 32'(m_err));
    endtask

    task automatic run(input int n, input logic [NCH-1:0] e);
        for (int k = 0; k < n; k++) step(1'b1, e, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        // Reset defaults: outputs held low, then natural periods 2/3/5.
        for (int k = 0; k < 3; k++) step(1'b0, '1, 1'b0, 1'b0, '0, '0);
        run(30, '1);

        // Shadowed reload on ch0 (H=4, then H=2 mid half-period).
        step(1'b1, '1, 1'b0, 1'b1, 2'd0, 8'd4);
        run(9, '1);
        step(1'b1, '1, 1'b0, 1'b1, 2'd0, 8'd2);
        run(12, '1);

        // Rejects: zero value, then out-of-range channel.
        step(1'b1, '1, 1'b0, 1'b1, 2'd1, 8'd0);
        step(1'b1, '1, 1'b0, 1'b1, 2'd3, 8'd4);
        run(8, '1);

        // Enable gating on ch0 for 5 cycles.
        step(1'b1, '1, 1'b0, 1'b1, 2'd0, 8'd4);
        run(6, '1);
        run(5, 3'b110);
        run(10, '1);

        // Sync with pending shadow on ch1 plus same-cycle load H=1 on ch0.
        step(1'b1, '1, 1'b0, 1'b1, 2'd1, 8'd2);
        step(1'b1, '1, 1'b1, 1'b1, 2'd0, 8'd1);
        run(10, '1);

        // Reset mid-operation after loads.
        step(1'b1, '1, 1'b0, 1'b1, 2'd2, 8'd7);
        run(2, '1);
        step(1'b0, '1, 1'b0, 1'b0, '0, '0);
        run(12, '1);

        // Randomised traffic.
        for (int k = 0; k < 4000; k++) begin
            logic [NCH-1:0] e;
            for (int b = 0; b < NCH; b++) e[b] = ($urandom_range(0, 99) < 85);
            step(($urandom_range(0, 299) != 0), e,
                 ($urandom_range(0, 24) == 0),
                 ($urandom_range(0, 4) == 0),
                 HW'($urandom_range(0, 3)),
                 CW'($urandom_range(0, 6)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
